m_stage_lsu: RTL and testbench
==============================

M_STAGE_LSU -- requirements
Module: m_stage_lsu

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16, the maximum number of BUSY cycles before the access is aborted.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004 SHALL have inputs M_Instr[31:0], M_AO[31:0] (effective address) and M_V2[31:0] (store data), all from the E/M pipeline register.
REQ-005 SHALL have input bus_rdata[31:0] (read data) and input bus_ready (1 bit: access complete this cycle).
REQ-006 SHALL have outputs bus_req (1), bus_we (1), bus_addr[31:0], bus_wdata[31:0] and bus_be[3:0] (byte enables, little-endian).
REQ-007 SHALL have outputs M_stall (1: freeze F/D/E/M), M_RD[31:0] (extended load data) and M_RD_valid (1).
REQ-008 SHALL have outputs M_AdEL (1), M_AdES (1) and M_BusErr (1).

Function
REQ-009 SHALL decode opcode M_Instr[31:26]: lw 100011, lh 100001, lhu 100101, lb 100000, lbu 100100, sw 101011, sh 101001, sb 101000; any other opcode SHALL be a non-memory instruction.
REQ-010 SHALL flag a misaligned access (word access: M_AO[1:0]!=0; half access: M_AO[0]!=0) as M_AdEL for loads and M_AdES for stores, combinationally while in IDLE, with no bus access and no stall.
REQ-011 SHALL implement FSM states IDLE, BUSY and DONE.
REQ-012 IDLE: an aligned memory op SHALL assert M_stall combinationally, register bus_addr={M_AO[31:2],2'b00} and bus_we/bus_be/bus_wdata, and go to BUSY on the next edge; otherwise the FSM SHALL stay in IDLE.
REQ-013 BUSY: bus_req=1 and M_stall=1; addr, we, be and wdata SHALL be held stable; on bus_ready=1 the FSM SHALL latch bus_rdata and go to DONE.
REQ-014 BUSY: a wait counter SHALL increment each cycle without bus_ready; when it reaches TIMEOUT-1, the FSM SHALL go to DONE, set M_BusErr for the DONE cycle and treat latched data as 0.
REQ-015 DONE: bus_req=0, M_stall=0 and M_RD_valid=1 for loads (0 for stores) for exactly one cycle; the next state SHALL be IDLE unconditionally.
REQ-016 A back-to-back memory op SHALL be detected in the IDLE cycle that follows DONE; DONE SHALL never re-issue the same instruction.
REQ-017 Byte enables: word 4'b1111; half 4'b0011<<(2*M_AO[1]); byte 4'b0001<<M_AO[1:0]; loads SHALL use the same enables.
REQ-018 Store data: sw M_V2; sh {2{M_V2[15:0]}}; sb {4{M_V2[7:0]}}.
REQ-019 Load extension on the latched word W with byte k = W[8k+7:8k]: lb/lh sign-extend, lbu/lhu zero-extend, lw pass through; the selected lane SHALL be taken from the latched M_AO[1:0].
REQ-020 Minimum latency SHALL be 2 stall cycles (IDLE detect, BUSY with bus_ready=1), with the result in DONE.
REQ-021 M_RD SHALL hold its value outside DONE; M_RD_valid and M_BusErr SHALL be 0 outside DONE.

Reset
REQ-022 On reset=1, without waiting for a clock edge: FSM=IDLE, wait counter=0, bus_req=0, bus_we=0, bus_be=0, bus_addr=0, bus_wdata=0, M_RD=0, M_RD_valid=0, M_BusErr=0.
REQ-023 Reset asserted mid-BUSY SHALL drop bus_req in the same cycle; the access SHALL be abandoned and any later bus_ready SHALL be ignored.
REQ-024 After reset is released, an in-flight memory op on M_Instr SHALL be treated as new and issued from IDLE.

Verification
REQ-025 lw, M_AO=0x1004, bus_ready on 1st BUSY cycle, bus_rdata=0xDEADBEEF -> bus_addr=0x1004, be=1111, M_stall high for 2 cycles, DONE M_RD=0xDEADBEEF.
REQ-026 lb, M_AO=0x2003, rdata=0x80FFFFFF -> be=1000, M_RD=0xFFFFFF80; lbu same -> M_RD=0x00000080.
REQ-027 sh, M_AO=0x3002, M_V2=0x1234ABCD, 3 wait cycles -> we=1, be=1100, wdata=0xABCDABCD held stable, M_stall high for 5 cycles, M_RD_valid=0.
REQ-028 lw, M_AO=0x1001 -> M_AdEL=1, bus_req never asserted, M_stall=0; sh at 0x1001 -> M_AdES=1.
REQ-029 lw with bus_ready never asserted -> DONE after 16 BUSY cycles, M_BusErr=1, M_RD=0, then IDLE.
REQ-030 reset pulsed in the 2nd BUSY cycle -> bus_req=0 and M_stall=0 before the next edge; bus_ready pulsed afterward -> no M_RD_valid.

Source files
------------

// File: rtl/m_stage_lsu.sv
// ---------------------------------------------------------------------------
// m_stage_lsu -- memory-stage load/store unit with a single-beat bus.
//
// Decodes the M-stage instruction, raises alignment exceptions, and runs one
// bus access per memory instruction through a small IDLE/BUSY/DONE FSM.
// The pipeline is frozen while the access is in flight. The result is
// presented for exactly one cycle in DONE.
//
// Ports
//   clk, reset       : clock; asynchronous active-high reset
//   M_Instr          : instruction in the M stage (opcode in [31:26])
//   M_AO             : effective address
//   M_V2             : store data
//   bus_rdata        : read data from the bus
//   bus_ready        : bus access completes this cycle
//   bus_req          : access in flight (BUSY)
//   bus_we           : write access
//   bus_addr         : word-aligned access address
//   bus_wdata        : lane-replicated store data
//   bus_be           : little-endian byte enables
//   M_stall          : freeze F/D/E/M
//   M_RD             : extended load data (held outside DONE)
//   M_RD_valid       : load result valid (DONE only)
//   M_AdEL / M_AdES  : misaligned load / store
//   M_BusErr         : access timed out (DONE only)
// ---------------------------------------------------------------------------
module m_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] M_Instr,
  input  logic [31:0] M_AO,
  input  logic [31:0] M_V2,
  input  logic [31:0] bus_rdata,
  input  logic        bus_ready,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_be,
  output logic        M_stall,
  output logic [31:0] M_RD,
  output logic        M_RD_valid,
  output logic        M_AdEL,
  output logic        M_AdES,
  output logic        M_BusErr
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BUSY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

  // Select the addressed lane of the latched word and extend it to 32 bits.
  function automatic logic [31:0] f_load_ext(input logic [31:0] word,
                                             input logic [1:0]  size,
                                             input logic        sgn,
                                             input logic [1:0]  lane);
    logic [31:0] shifted;
    logic [7:0]  b;
    logic [15:0] h;
    shifted = word >> {lane, 3'b000};
    b = shifted[7:0];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SZ_BYTE: f_load_ext = sgn ? {{24{b[7]}}, b} : {24'd0, b};
      SZ_HALF: f_load_ext = sgn ? {{16{h[15]}}, h} : {16'd0, h};
      default: f_load_ext = word;
    endcase
  endfunction

  logic [1:0]    r_state;
  logic [1:0]    w_next;
  logic [CW-1:0] r_wait_cnt;
  logic          r_bus_we;
  logic [3:0]    r_bus_be;
  logic [31:0]   r_bus_addr;
  logic [31:0]   r_bus_wdata;
  logic [1:0]    r_lane;
  logic [1:0]    r_size;
  logic          r_signed;
  logic          r_is_load;
  logic [31:0]   r_m_rd;
  logic          r_rd_valid;
  logic          r_bus_err;

  logic [5:0]    w_op;
  logic          w_is_mem;
  logic          w_is_load;
  logic          w_signed;
  logic [1:0]    w_size;
  logic          w_misalign;
  logic [3:0]    w_be;
  logic [31:0]   w_wdata;
  logic          w_issue;
  logic          w_timeout;
  logic          w_finish;
  logic          w_unused;

  assign w_op     = M_Instr[31:26];
  assign w_unused = ^M_Instr[25:0];

  // Opcode decode: memory/load flags, access size and signedness.
  always_comb begin
    w_is_mem  = 1'b1;
    w_is_load = 1'b0;
    w_signed  = 1'b0;
    w_size    = SZ_WORD;
    case (w_op)
      6'b100011: begin w_is_load = 1'b1; w_size = SZ_WORD; end
      6'b100001: begin w_is_load = 1'b1; w_size = SZ_HALF; w_signed = 1'b1; end
      6'b100101: begin w_is_load = 1'b1; w_size = SZ_HALF; end
      6'b100000: begin w_is_load = 1'b1; w_size = SZ_BYTE; w_signed = 1'b1; end
      6'b100100: begin w_is_load = 1'b1; w_size = SZ_BYTE; end
      6'b101011: w_size = SZ_WORD;
      6'b101001: w_size = SZ_HALF;
      6'b101000: w_size = SZ_BYTE;
      default:   w_is_mem = 1'b0;
    endcase
  end

  // Alignment check, byte enables and lane-replicated store data.
  always_comb begin
    w_misalign = 1'b0;
    w_be       = 4'b1111;
    w_wdata    = M_V2;
    case (w_size)
      SZ_WORD: begin
        w_misalign = (M_AO[1:0] != 2'b00);
        w_be       = 4'b1111;
        w_wdata    = M_V2;
      end
      SZ_HALF: begin
        w_misalign = M_AO[0];
        w_be       = 4'b0011 << {M_AO[1], 1'b0};
        w_wdata    = {2{M_V2[15:0]}};
      end
      SZ_BYTE: begin
        w_misalign = 1'b0;
        w_be       = 4'b0001 << M_AO[1:0];
        w_wdata    = {4{M_V2[7:0]}};
      end
      default: begin
        w_misalign = 1'b0;
        w_be       = 4'b1111;
        w_wdata    = M_V2;
      end
    endcase
  end

  assign w_issue   = (r_state == S_IDLE) && w_is_mem && !w_misalign;
  // bus_ready takes priority over the timeout on the last allowed cycle.
  assign w_timeout = (r_state == S_BUSY) && !bus_ready && (r_wait_cnt == CNT_MAX);
  assign w_finish  = (r_state == S_BUSY) && (bus_ready || w_timeout);

  // Next-state logic; DONE always returns to IDLE so it never re-issues.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_issue) w_next = S_BUSY;
        else         w_next = S_IDLE;
      end
      S_BUSY: begin
        if (w_finish) w_next = S_DONE;
        else          w_next = S_BUSY;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // State register and BUSY wait counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state <= w_next;
      if ((r_state == S_BUSY) && !w_finish) begin
        r_wait_cnt <= r_wait_cnt + CW'(1);
      end else begin
        r_wait_cnt <= '0;
      end
    end
  end

  // Capture the bus request fields and load attributes at issue; held in BUSY.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_bus_we    <= 1'b0;
      r_bus_be    <= 4'b0000;
      r_bus_addr  <= 32'd0;
      r_bus_wdata <= 32'd0;
      r_lane      <= 2'b00;
      r_size      <= SZ_BYTE;
      r_signed    <= 1'b0;
      r_is_load   <= 1'b0;
    end else if (w_issue) begin
      r_bus_we    <= !w_is_load;
      r_bus_be    <= w_be;
      r_bus_addr  <= {M_AO[31:2], 2'b00};
      r_bus_wdata <= w_wdata;
      r_lane      <= M_AO[1:0];
      r_size      <= w_size;
      r_signed    <= w_signed;
      r_is_load   <= w_is_load;
    end
  end

  // Result registers: loaded on BUSY->DONE, valid/error live only in DONE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_m_rd     <= 32'd0;
      r_rd_valid <= 1'b0;
      r_bus_err  <= 1'b0;
    end else if (w_finish) begin
      r_rd_valid <= r_is_load;
      r_bus_err  <= w_timeout;
      if (r_is_load) begin
        // A timed-out access reads as zero.
        r_m_rd <= f_load_ext(bus_ready ? bus_rdata : 32'd0, r_size, r_signed, r_lane);
      end
    end else begin
      r_rd_valid <= 1'b0;
      r_bus_err  <= 1'b0;
    end
  end

  assign bus_req    = (r_state == S_BUSY);
  assign bus_we     = r_bus_we;
  assign bus_be     = r_bus_be;
  assign bus_addr   = r_bus_addr;
  assign bus_wdata  = r_bus_wdata;
  // Stall is gated by reset so an abandoned access releases the pipe at once.
  assign M_stall    = !reset && (w_issue || (r_state == S_BUSY));
  assign M_RD       = r_m_rd;
  assign M_RD_valid = r_rd_valid;
  assign M_BusErr   = r_bus_err;
  assign M_AdEL     = (r_state == S_IDLE) && w_is_mem && w_is_load && w_misalign;
  assign M_AdES     = (r_state == S_IDLE) && w_is_mem && !w_is_load && w_misalign;

endmodule

// File: tb/tb_m_stage_lsu.sv
// ---------------------------------------------------------------------------
// tb_m_stage_lsu -- self-checking bench for m_stage_lsu: a table of directed
// vectors, a reset-abandon sequence, and randomized transactions whose
// expectations come from an arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_m_stage_lsu;
  localparam int TIMEOUT = 16;

  localparam logic [5:0] OP_LW  = 6'b100011;
  localparam logic [5:0] OP_LH  = 6'b100001;
  localparam logic [5:0] OP_LHU = 6'b100101;
  localparam logic [5:0] OP_LB  = 6'b100000;
  localparam logic [5:0] OP_LBU = 6'b100100;
  localparam logic [5:0] OP_SW  = 6'b101011;
  localparam logic [5:0] OP_SH  = 6'b101001;
  localparam logic [5:0] OP_SB  = 6'b101000;
  localparam logic [5:0] OP_ADD = 6'b000000;
  localparam logic [31:0] NOP   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] M_Instr, M_AO, M_V2, bus_rdata;
  logic        bus_ready;
  logic        bus_req, bus_we, M_stall, M_RD_valid, M_AdEL, M_AdES, M_BusErr;
  logic [31:0] bus_addr, bus_wdata, M_RD;
  logic [3:0]  bus_be;

  always #5 clk = ~clk;

  m_stage_lsu #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .M_Instr(M_Instr), .M_AO(M_AO), .M_V2(M_V2),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_be(bus_be),
    .M_stall(M_stall), .M_RD(M_RD), .M_RD_valid(M_RD_valid),
    .M_AdEL(M_AdEL), .M_AdES(M_AdES), .M_BusErr(M_BusErr)
  );

  typedef struct {
    logic [5:0]  opc;
    logic [31:0] ao;
    logic [31:0] v2;
    logic [31:0] rdata;
    int          waits;   // BUSY cycles before bus_ready; >= TIMEOUT means never
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] rd;
    int          stall;   // total M_stall cycles; 0 means no access
    logic        valid;
    logic        err;
    logic        adel;
    logic        ades;
    bit          b2b;     // next op is presented during this op's DONE cycle
  } vec_t;

  int          errors = 0;
  int          checks = 0;
  bit          in_done = 1'b0;
  logic [31:0] model_rd = 32'd0;
  vec_t        tbl[15];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: access size, alignment and lane math in plain arithmetic.
  function automatic int nbytes(input logic [5:0] o);
    case (o)
      OP_LW, OP_SW:         return 4;
      OP_LH, OP_LHU, OP_SH: return 2;
      OP_LB, OP_LBU, OP_SB: return 1;
      default:              return 0;
    endcase
  endfunction

  function automatic bit is_load(input logic [5:0] o);
    return (o == OP_LW) || (o == OP_LH) || (o == OP_LHU) || (o == OP_LB) || (o == OP_LBU);
  endfunction

  function automatic vec_t model(input logic [5:0] opc, input logic [31:0] ao, input logic [31:0] v2,
                                 input logic [31:0] rdata, input int waits, input logic [31:0] prev_rd);
    vec_t v;
    int nb, off;
    logic [31:0] word, val, mask;
    bit tmo;
    v = '{opc, ao, v2, rdata, waits, 4'h0, 32'h0, prev_rd, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    nb = nbytes(opc);
    if (nb == 0) return v;
    if ((ao % nb) != 0) begin
      v.adel = is_load(opc);
      v.ades = !is_load(opc);
      return v;
    end
    off     = int'(ao % 4);
    v.be    = 4'(((1 << nb) - 1) << off);
    v.wdata = (nb == 4) ? v2 : (nb == 2) ? (v2 & 32'hFFFF) * 32'h0001_0001
                                         : (v2 & 32'hFF) * 32'h0101_0101;
    tmo     = (waits >= TIMEOUT);
    v.stall = 1 + (tmo ? TIMEOUT : waits + 1);
    v.err   = tmo;
    v.valid = is_load(opc);
    if (is_load(opc)) begin
      word = tmo ? 32'd0 : rdata;
      mask = (nb == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * nb)) - 32'd1);
      val  = (word >> (8 * off)) & mask;
      if (((opc == OP_LB) || (opc == OP_LH)) && val[8 * nb - 1]) val = val | ~mask;
      v.rd = val;
    end
    return v;
  endfunction

  function automatic vec_t mkv(input logic [5:0] opc, input logic [31:0] ao, input logic [31:0] v2,
                               input logic [31:0] rdata, input int waits, input logic [3:0] be,
                               input logic [31:0] wdata, input logic [31:0] rd, input int stall,
                               input logic valid, input logic err, input logic adel,
                               input logic ades, input bit b2b);
    vec_t v;
    v = '{opc, ao, v2, rdata, waits, be, wdata, rd, stall, valid, err, adel, ades, b2b};
    return v;
  endfunction

  // Drive one instruction and check it from IDLE through DONE; starts mid-cycle.
  task automatic run_op(input vec_t v);
    int  busy_n, stall_n;
    bit  ended;
    M_Instr   = {v.opc, 26'($urandom)};
    M_AO      = v.ao;
    M_V2      = v.v2;
    bus_rdata = v.rdata;
    bus_ready = 1'b0;
    #1;
    if (in_done) begin
      chk("done_no_stall", 32'(M_stall), 32'd0);
      chk("done_no_req", 32'(bus_req), 32'd0);
      @(negedge clk); #1;
    end
    in_done = 1'b0;
    chk("idle_adel", 32'(M_AdEL), 32'(v.adel));
    chk("idle_ades", 32'(M_AdES), 32'(v.ades));
    chk("idle_stall", 32'(M_stall), 32'(v.stall != 0));
    chk("idle_req", 32'(bus_req), 32'd0);
    if (v.stall == 0) begin
      @(negedge clk); #1;
      chk("noacc_req", 32'(bus_req), 32'd0);
      chk("noacc_stall", 32'(M_stall), 32'd0);
      M_Instr = NOP;
      @(negedge clk); #1;
      return;
    end
    stall_n = 1;
    busy_n  = 0;
    ended   = 1'b0;
    for (int c = 0; c < 64 && !ended; c++) begin
      @(negedge clk); #1;
      if (bus_req) begin
        busy_n++;
        stall_n += int'(M_stall);
        chk("busy_addr", bus_addr, v.ao & 32'hFFFF_FFFC);
        chk("busy_we", 32'(bus_we), 32'(!is_load(v.opc)));
        chk("busy_be", 32'(bus_be), 32'(v.be));
        if (!is_load(v.opc)) chk("busy_wdata", bus_wdata, v.wdata);
        bus_ready = ((busy_n - 1) == v.waits);
      end else begin
        ended     = 1'b1;
        bus_ready = 1'b0;
        stall_n  += int'(M_stall);
        chk("stall_cycles", 32'(stall_n), 32'(v.stall));
        chk("done_valid", 32'(M_RD_valid), 32'(v.valid));
        chk("done_buserr", 32'(M_BusErr), 32'(v.err));
        chk("done_rd", M_RD, v.rd);
      end
    end
    if (!ended) begin
      checks++;
      errors++;
      $display("FAIL done_reached: no DONE within 64 cycles, busy=%0d", busy_n);
      return;
    end
    if (v.b2b) begin
      in_done = 1'b1;
    end else begin
      M_Instr = NOP;
      @(negedge clk); #1;
      chk("idle_rd_hold", M_RD, v.rd);
      chk("idle_valid0", 32'(M_RD_valid), 32'd0);
      chk("idle_err0", 32'(M_BusErr), 32'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    logic [5:0] ops[9];
    logic [31:0] ao;
    int nb, w;

    reset = 1'b1; M_Instr = NOP; M_AO = 32'd0; M_V2 = 32'd0;
    bus_rdata = 32'd0; bus_ready = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_req", 32'(bus_req), 32'd0);
    chk("rst_we", 32'(bus_we), 32'd0);
    chk("rst_be", 32'(bus_be), 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk("rst_wdata", bus_wdata, 32'd0);
    chk("rst_rd", M_RD, 32'd0);
    chk("rst_valid", 32'(M_RD_valid), 32'd0);
    chk("rst_buserr", 32'(M_BusErr), 32'd0);
    chk("rst_stall", 32'(M_stall), 32'd0);
    reset = 1'b0;

    // opc, ao, v2, rdata, waits, be, wdata, rd, stall, valid, err, adel, ades, b2b
    tbl[0]  = mkv(OP_LW,  32'h1004, 32'h0, 32'hDEADBEEF, 0,  4'b1111, 32'h0, 32'hDEADBEEF, 2,  1, 0, 0, 0, 1);
    tbl[1]  = mkv(OP_LB,  32'h2003, 32'h0, 32'h80FFFFFF, 0,  4'b1000, 32'h0, 32'hFFFFFF80, 2,  1, 0, 0, 0, 0);
    tbl[2]  = mkv(OP_LBU, 32'h2003, 32'h0, 32'h80FFFFFF, 1,  4'b1000, 32'h0, 32'h00000080, 3,  1, 0, 0, 0, 0);
    tbl[3]  = mkv(OP_SH,  32'h3002, 32'h1234ABCD, 32'h0, 3,  4'b1100, 32'hABCDABCD, 32'h00000080, 5, 0, 0, 0, 0, 1);
    tbl[4]  = mkv(OP_LW,  32'h1001, 32'h0, 32'h0, 0,         4'b0000, 32'h0, 32'h0, 0,  0, 0, 1, 0, 0);
    tbl[5]  = mkv(OP_SH,  32'h1001, 32'h0, 32'h0, 0,         4'b0000, 32'h0, 32'h0, 0,  0, 0, 0, 1, 0);
    tbl[6]  = mkv(OP_LW,  32'h4000, 32'h0, 32'h55555555, 99, 4'b1111, 32'h0, 32'h0, 17, 1, 1, 0, 0, 0);
    tbl[7]  = mkv(OP_LH,  32'h5002, 32'h0, 32'h80017FFF, 2,  4'b1100, 32'h0, 32'hFFFF8001, 4,  1, 0, 0, 0, 0);
    tbl[8]  = mkv(OP_LHU, 32'h5000, 32'h0, 32'h8001F00F, 0,  4'b0011, 32'h0, 32'h0000F00F, 2,  1, 0, 0, 0, 0);
    tbl[9]  = mkv(OP_SB,  32'h6001, 32'hAABBCC5A, 32'h0, 0,  4'b0010, 32'h5A5A5A5A, 32'h0000F00F, 2, 0, 0, 0, 0, 0);
    tbl[10] = mkv(OP_SW,  32'h7008, 32'hCAFEF00D, 32'h0, 1,  4'b1111, 32'hCAFEF00D, 32'h0000F00F, 3, 0, 0, 0, 0, 0);
    tbl[11] = mkv(OP_ADD, 32'h1001, 32'h0, 32'h0, 0,         4'b0000, 32'h0, 32'h0, 0,  0, 0, 0, 0, 0);
    tbl[12] = mkv(OP_SB,  32'h600B, 32'h00000011, 32'h0, 99, 4'b1000, 32'h11111111, 32'h0000F00F, 17, 0, 1, 0, 0, 0);
    tbl[13] = mkv(OP_LB,  32'h8000, 32'h0, 32'h0000007F, 0,  4'b0001, 32'h0, 32'h0000007F, 2,  1, 0, 0, 0, 0);
    tbl[14] = mkv(OP_LW,  32'hA000, 32'h0, 32'h12345678, TIMEOUT - 1, 4'b1111, 32'h0, 32'h12345678, 17, 1, 0, 0, 0, 0);

    for (int i = 0; i < 15; i++) begin
      run_op(tbl[i]);
      if (tbl[i].stall != 0) model_rd = tbl[i].rd;
    end

    // Reset in the 2nd BUSY cycle abandons the access; later bus_ready is ignored.
    v = model(OP_LW, 32'h9000, 32'h0, 32'h0BADF00D, 0, 32'd0);
    M_Instr = {OP_LW, 26'd0}; M_AO = 32'h9000; bus_rdata = 32'h0BADF00D;
    @(negedge clk); #1;
    @(negedge clk); #1;
    chk("rb_busy2_req", 32'(bus_req), 32'd1);
    reset = 1'b1;
    #1;
    chk("rb_req_drop", 32'(bus_req), 32'd0);
    chk("rb_stall_drop", 32'(M_stall), 32'd0);
    chk("rb_rd_clear", M_RD, 32'd0);
    @(negedge clk); #1;
    bus_ready = 1'b1;
    @(negedge clk); #1;
    chk("rb_no_valid", 32'(M_RD_valid), 32'd0);
    chk("rb_no_req", 32'(bus_req), 32'd0);
    bus_ready = 1'b0;
    reset = 1'b0;
    model_rd = 32'd0;
    // The still-present lw is issued afresh from IDLE.
    run_op(v);
    model_rd = v.rd;

    ops = '{OP_LW, OP_LH, OP_LHU, OP_LB, OP_LBU, OP_SW, OP_SH, OP_SB, OP_ADD};
    for (int n = 0; n < 200; n++) begin
      logic [5:0] o;
      o  = ops[$urandom_range(0, 8)];
      ao = $urandom;
      nb = nbytes(o);
      if ($urandom_range(0, 3) != 0) begin
        if (nb == 4) ao[1:0] = 2'b00;
        if (nb == 2) ao[0] = 1'b0;
      end
      case ($urandom_range(0, 9))
        0:       w = TIMEOUT + 3;
        1:       w = TIMEOUT - 1;
        default: w = $urandom_range(0, 4);
      endcase
      v = model(o, ao, $urandom, $urandom, w, model_rd);
      v.b2b = ($urandom_range(0, 1) == 1);
      run_op(v);
      if (v.stall != 0) model_rd = v.rd;
    end
    if (in_done) begin
      M_Instr = NOP;
      @(negedge clk); #1;
      in_done = 1'b0;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
